// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches and queues returned words with their PCs.
// Latency: a word accepted in cycle N is written at the end of N+1 and is visible at the head in N+2 (no bypass).
// Backpressure: a request is raised only while free entries exceed in-flight requests; im_busy_i holds the address.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect sets fetch_fault_o and halts fetch).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic [31:0] im_addr_o,
  output logic        im_req_o,
  input  logic        im_busy_i,
  input  logic [31:0] im_dout_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        fetch_fault_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // fetch address state
  logic [31:0] r_fetch_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic        r_run;

  // instruction buffer; pointers carry one extra bit so full and empty differ
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [31:0] r_mem_instr [FIFO_DEPTH];
  logic [31:0] r_mem_pc    [FIFO_DEPTH];

  logic [AW:0] w_count;
  logic [AW:0] w_free;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_fault_hold;
  logic [31:0] w_redir_pc;

  // redirect target handling: the low address bits never reach the fetch PC
  assign w_redir_pc = {redirect_pc_i[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;

  // fault is set by a misaligned redirect and cleared by the next aligned one
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fault <= 1'b0;
    end else if (redirect_i) begin
      r_fault <= |redirect_pc_i[1:0];
    end
  end

  assign w_fault_hold  = r_fault;
  assign fetch_fault_o = r_fault;
`else
  logic w_unused_pc_lsb;
  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];
  assign w_fault_hold    = 1'b0;
  assign fetch_fault_o   = 1'b0;
`endif

  assign w_count = r_wptr - r_rptr;
  assign w_free  = (AW+1)'(FIFO_DEPTH) - w_count;
  assign w_empty = (r_wptr == r_rptr);

  // Requests are withheld during a redirect cycle so the stale address is never accepted.
  assign im_req_o  = r_run & ~w_fault_hold & ~redirect_i &
                     (w_free > {{AW{1'b0}}, r_inflight});
  assign im_addr_o = r_fetch_pc;
  assign w_accept  = im_req_o & ~im_busy_i;

  // Redirect wins over both buffer operations.
  assign w_push = r_inflight & ~redirect_i;
  assign w_pop  = instr_valid_o & instr_ready_i & ~redirect_i;

  assign instr_valid_o = ~w_empty;
  assign instr_o       = w_empty ? 32'h0 : r_mem_instr[r_rptr[AW-1:0]];
  assign instr_pc_o    = w_empty ? 32'h0 : r_mem_pc[r_rptr[AW-1:0]];

  // fetch PC advance, in-flight tracking and redirect load
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_run         <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (redirect_i) begin
        r_fetch_pc <= w_redir_pc;
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_accept;
        if (w_accept) begin
          r_inflight_pc <= r_fetch_pc;
          r_fetch_pc    <= r_fetch_pc + 32'd4;
        end
      end
    end
  end

  // buffer pointers: flush on redirect, otherwise independent push/pop
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (redirect_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // buffer storage: the returning word is paired with the PC it was fetched from
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_instr[r_wptr[AW-1:0]] <= im_dout_i;
      r_mem_pc[r_wptr[AW-1:0]]    <= r_inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model plus PC/instruction scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Directed scenarios are followed by a short randomised stall/ready/redirect phase.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] im_addr_o;
  logic        im_req_o;
  logic        im_busy_i;
  logic [31:0] im_dout_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        fetch_fault_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sb_pc [$];
  logic [31:0] exp_pc;
  logic        mem_acc = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .im_addr_o     (im_addr_o),
    .im_req_o      (im_req_o),
    .im_busy_i     (im_busy_i),
    .im_dout_i     (im_dout_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .fetch_fault_o (fetch_fault_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory model and scoreboard: words return one cycle after acceptance;
  // accepted PCs are queued and must emerge from the head in order.
  always @(negedge clk_i) begin
    im_dout_i = mem_acc ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    if (!rst_n_i) begin
      sb_pc.delete();
      exp_pc  = RST_PC;
      mem_acc = 1'b0;
    end else if (redirect_i) begin
      chk("redir_req", 32'(im_req_o), 32'd0);
      sb_pc.delete();
      exp_pc  = redirect_pc_i & 32'hFFFF_FFFC;
      mem_acc = 1'b0;
    end else begin
      if (instr_valid_o && instr_ready_i) begin
        if (sb_pc.size() == 0) begin
          chk("pop_unexpected", 32'(sb_pc.size()), 32'd1);
        end else begin
          logic [31:0] p;
          p = sb_pc.pop_front();
          chk("pop_pc", instr_pc_o, p);
          chk("pop_instr", instr_o, mem_word(p));
        end
      end
      mem_acc  = im_req_o && !im_busy_i;
      mem_addr = im_addr_o;
      if (mem_acc) begin
        chk("req_addr", im_addr_o, exp_pc);
        sb_pc.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic after_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_i    = 1'b1;
    redirect_pc_i = tgt;
    after_edge();
    redirect_i    = 1'b0;
  endtask

  initial begin
    rst_n_i       = 1'b0;
    im_busy_i     = 1'b0;
    im_dout_i     = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b1;

    // reset state
    @(negedge clk_i);
    chk("rst_req",   32'(im_req_o),      32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o,            32'h0);
    chk("rst_ipc",   instr_pc_o,         32'h0);
    chk("rst_fault", 32'(fetch_fault_o), 32'd0);
    chk("rst_addr",  im_addr_o,          RST_PC);

    // sequential fetch after reset release
    after_edge();
    rst_n_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("seq_req0",  32'(im_req_o), 32'd1);
    chk("seq_addr0", im_addr_o, 32'h100);
    @(negedge clk_i);
    chk("seq_addr1", im_addr_o, 32'h104);
    @(negedge clk_i);
    chk("seq_addr2", im_addr_o, 32'h108);
    chk("seq_valid", 32'(instr_valid_o), 32'd1);
    chk("seq_ipc",   instr_pc_o, 32'h100);

    // decode stalled: buffer fills to depth and fetch stops
    after_edge();
    instr_ready_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    chk("full_req",   32'(im_req_o), 32'd0);
    chk("full_valid", 32'(instr_valid_o), 32'd1);
    chk("full_depth", 32'(sb_pc.size()), 32'd4);
    after_edge();
    instr_ready_i = 1'b1;
    repeat (8) after_edge();

    // memory stall: redirect to 0x10 while busy, address held for 3 cycles
    im_busy_i = 1'b1;
    do_redirect(32'h10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("busy_addr", im_addr_o, 32'h10);
      chk("busy_req",  32'(im_req_o), 32'd1);
      after_edge();
    end
    im_busy_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("busy_ipc", instr_pc_o, 32'h10);

    // redirect with three buffered entries and one request in flight
    after_edge();
    instr_ready_i = 1'b0;
    do_redirect(32'h500);
    repeat (4) after_edge();
    instr_ready_i = 1'b1;
    do_redirect(32'h2000);
    @(negedge clk_i);
    chk("flush_valid", 32'(instr_valid_o), 32'd0);
    chk("flush_addr",  im_addr_o, 32'h2000);
    chk("flush_req",   32'(im_req_o), 32'd1);
    repeat (6) after_edge();

    // address wrap at the top of the space
    do_redirect(32'hFFFF_FFFC);
    @(negedge clk_i);
    chk("wrap_addr0", im_addr_o, 32'hFFFF_FFFC);
    @(negedge clk_i);
    chk("wrap_addr1", im_addr_o, 32'h0);
    repeat (6) after_edge();

`ifdef FETCH_MISALIGN_TRAP_EN
    do_redirect(32'h2002);
    @(negedge clk_i);
    chk("mis_fault", 32'(fetch_fault_o), 32'd1);
    chk("mis_req",   32'(im_req_o), 32'd0);
    repeat (3) after_edge();
    chk("mis_hold",  32'(im_req_o), 32'd0);
    do_redirect(32'h3000);
    @(negedge clk_i);
    chk("mis_clear", 32'(fetch_fault_o), 32'd0);
    chk("mis_addr",  im_addr_o, 32'h3000);
    chk("mis_req1",  32'(im_req_o), 32'd1);
`else
    do_redirect(32'h3002);
    @(negedge clk_i);
    chk("lsb_addr",  im_addr_o, 32'h3000);
    chk("lsb_fault", 32'(fetch_fault_o), 32'd0);
`endif
    repeat (6) after_edge();

    // reset asserted mid-operation
    rst_n_i = 1'b0;
    @(negedge clk_i);
    chk("mrst_valid", 32'(instr_valid_o), 32'd0);
    chk("mrst_req",   32'(im_req_o), 32'd0);
    chk("mrst_addr",  im_addr_o, RST_PC);
    after_edge();
    rst_n_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("mrst_req1",  32'(im_req_o), 32'd1);
    after_edge();

    // randomised stalls, decode backpressure and occasional redirects
    for (int i = 0; i < 300; i++) begin
      im_busy_i     = ($urandom_range(0, 3) == 0);
      instr_ready_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_i    = 1'b1;
        redirect_pc_i = $urandom() & 32'hFFFF_FFFC;
      end else begin
        redirect_i    = 1'b0;
      end
      after_edge();
    end
    redirect_i    = 1'b0;
    im_busy_i     = 1'b0;
    instr_ready_i = 1'b1;
    repeat (12) after_edge();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
